// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - single-outstanding instruction fetch sequencer with halt causes
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic [31:0] io_pc,
  output logic [31:0] io_inst,
  output logic        io_inst_valid,
  input  logic        io_wb_done,
  input  logic [31:0] io_pc_next,
  input  logic        io_is_unknown_instruction,
  output logic        io_halted,
  output logic [1:0]  io_halt_cause,
  output logic [31:0] io_retired
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misaligned;

  assign misaligned = (io_pc_next[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      retired_q <= 32'h0;
      cause_q   <= 2'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (io_imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (io_imem_resp_valid)    state_d = S_EXEC;
        else if (cnt_q == TO_LAST) state_d = S_HALT;
      end
      S_EXEC: begin
        if (io_is_unknown_instruction) state_d = S_HALT;
        else if (io_wb_done)           state_d = misaligned ? S_HALT : S_FETCH;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  // Architectural state only moves on the transitions chosen above; HALT freezes everything.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_FETCH: if (io_imem_req_ready) cnt_d = 8'd0;
      S_WAIT: begin
        if (io_imem_resp_valid)    inst_d  = io_imem_resp_data;
        else if (cnt_q == TO_LAST) cause_d = CAUSE_TIMEOUT;
        else                       cnt_d   = cnt_q + 8'd1;
      end
      S_EXEC: begin
        if (io_is_unknown_instruction) begin
          cause_d = CAUSE_ILLEGAL;
        end else if (io_wb_done) begin
          if (misaligned) begin
            cause_d = CAUSE_MISALIGN;
          end else begin
            pc_d      = io_pc_next;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      S_HALT: ;
    endcase
  end

  // Reset forces FETCH, so the request must be masked while reset is held.
  always_comb begin
    io_imem_req_valid = (state_q == S_FETCH) && !reset;
    io_imem_req_addr  = pc_q;
    io_pc             = pc_q;
    io_inst           = inst_q;
    io_inst_valid     = (state_q == S_EXEC);
    io_halted         = (state_q == S_HALT);
    io_halt_cause     = cause_q;
    io_retired        = retired_q;
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed and randomized checks of ifu_fetch_ctrl against a transaction model
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          TO  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic [31:0] pc, inst, retired;
  logic        inst_valid, wb_done = 1'b0, unk = 1'b0, halted;
  logic [31:0] pc_next = 32'h0;
  logic [1:0]  cause;

  int checks = 0;
  int failures = 0;

  // Transaction-level view: are we requesting, awaiting a word, or holding one?
  int          m_phase;   // 0 requesting, 1 awaiting response, 2 holding instruction
  bit          m_halted;
  int          m_waited;
  logic [31:0] m_pc, m_inst, m_ret;
  logic [1:0]  m_cause;

  ifu_fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready),
    .io_imem_req_addr(req_addr),
    .io_imem_resp_valid(resp_valid), .io_imem_resp_data(resp_data),
    .io_pc(pc), .io_inst(inst), .io_inst_valid(inst_valid),
    .io_wb_done(wb_done), .io_pc_next(pc_next),
    .io_is_unknown_instruction(unk),
    .io_halted(halted), .io_halt_cause(cause), .io_retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_halted = 0; m_waited = 0;
    m_pc = RPC; m_inst = 32'h0; m_ret = 32'h0; m_cause = 2'd0;
  endtask

  task automatic model_step();
    if (m_halted) return;
    if (m_phase == 0) begin
      if (req_ready) begin m_phase = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      if (resp_valid) begin
        m_inst = resp_data; m_phase = 2;
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_halted = 1; m_cause = 2'd2; end
      end
    end else begin
      if (unk) begin
        m_halted = 1; m_cause = 2'd1;
      end else if (wb_done) begin
        if (pc_next % 4 != 0) begin
          m_halted = 1; m_cause = 2'd3;
        end else begin
          m_pc = pc_next; m_ret = m_ret + 1; m_phase = 0;
        end
      end
    end
  endtask

  task automatic check_all(input bool_in_reset);
    chk("req_valid", req_valid, !bool_in_reset && !m_halted && m_phase == 0);
    chk("req_addr",  req_addr,  m_pc);
    chk("pc",        pc,        m_pc);
    chk("inst",      inst,      m_inst);
    chk("inst_valid", inst_valid, !m_halted && m_phase == 2);
    chk("halted",    halted,    m_halted);
    chk("cause",     cause,     m_cause);
    chk("retired",   retired,   m_ret);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all(0);
  endtask

  // Asserted mid-cycle so the asynchronous effect is observed before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all(1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_all(0);
    chk("first_req_valid", req_valid, 1'b1);
    chk("first_req_addr", req_addr, RPC);
  endtask

  task automatic idle_inputs();
    req_ready = 0; resp_valid = 0; wb_done = 0; unk = 0;
  endtask

  initial begin
    model_reset();
    #12;
    do_reset();

    // Basic fetch/retire; a response coincident with the handshake is dropped.
    req_ready = 1; resp_valid = 1; resp_data = 32'hDEAD_BEEF;
    tick();
    chk("handshake_to_wait", req_valid, 1'b0);
    req_ready = 0; resp_valid = 0;
    tick();
    resp_valid = 1; resp_data = 32'h0000_0013;
    tick();
    resp_valid = 0; resp_data = 32'hFFFF_FFFF;
    chk("inst_latched", inst, 32'h0000_0013);
    chk("inst_valid_exec", inst_valid, 1'b1);
    tick(); tick();
    chk("exec_hold_inst", inst, 32'h0000_0013);
    wb_done = 1; pc_next = 32'h8000_0004;
    tick();
    wb_done = 0;
    chk("retire_pc", pc, 32'h8000_0004);
    chk("retire_count", retired, 32'd1);
    chk("next_req_addr", req_addr, 32'h8000_0004);
    chk("next_req_valid", req_valid, 1'b1);

    // Long backpressure in FETCH never times out, then timeout in WAIT.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_addr", req_addr, 32'h8000_0000);
    end
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("stall_then_wait", req_valid, 1'b0);
    tick(); tick(); tick();
    chk("not_yet_timeout", halted, 1'b0);
    tick();
    chk("timeout_halt", halted, 1'b1);
    chk("timeout_cause", cause, 2'd2);
    req_ready = 1; resp_valid = 1; wb_done = 1; pc_next = 32'h100;
    tick(); tick();
    chk("halt_absorbing_req", req_valid, 1'b0);
    idle_inputs();

    // Illegal instruction wins over wb_done.
    do_reset();
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_data = 32'hFFFF_FFFF; tick(); resp_valid = 0;
    unk = 1; wb_done = 1; pc_next = 32'h8000_0004;
    tick();
    idle_inputs();
    chk("illegal_cause", cause, 2'd1);
    chk("illegal_pc", pc, 32'h8000_0000);
    chk("illegal_retired", retired, 32'd0);

    // Misaligned next PC.
    do_reset();
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_data = 32'h0000_0067; tick(); resp_valid = 0;
    wb_done = 1; pc_next = 32'h8000_0102;
    tick();
    idle_inputs();
    chk("misalign_cause", cause, 2'd3);
    chk("misalign_pc", pc, 32'h8000_0000);

    // Reset pulsed while awaiting a response; a late response is ignored.
    do_reset();
    req_ready = 1; tick(); req_ready = 0;
    do_reset();
    resp_valid = 1; resp_data = 32'h1234_5678;
    tick();
    resp_valid = 0;
    chk("late_resp_req_valid", req_valid, 1'b1);
    chk("late_resp_addr", req_addr, 32'h8000_0000);
    chk("late_resp_inst", inst, 32'h0);
    chk("late_resp_retired", retired, 32'd0);

    // Randomized traffic; halts are cleared by reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (halted && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 399) == 0) do_reset();
      req_ready  = ($urandom_range(0, 1) == 1);
      resp_valid = ($urandom_range(0, 9) < 4);
      resp_data  = $urandom;
      wb_done    = ($urandom_range(0, 9) < 4);
      unk        = ($urandom_range(0, 49) == 0);
      pc_next    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 29) == 0) pc_next[1:0] = 2'($urandom_range(1, 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT, default 255, maximum WAIT cycles before a fetch is declared lost (range 1..255).
REQ-003 SHALL provide port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port io_imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL provide port io_imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL provide port io_imem_req_addr  output  32  fetch address; equals io_pc.
REQ-008 SHALL provide port io_imem_resp_valid  input  1  fetched word valid.
REQ-009 SHALL provide port io_imem_resp_data  input  32  fetched instruction word.
REQ-010 SHALL provide port io_pc  output  32  current PC register.
REQ-011 SHALL provide port io_inst  output  32  latched instruction for decode and next-PC logic.
REQ-012 SHALL provide port io_inst_valid  output  1  io_inst valid; high only in EXEC.
REQ-013 SHALL provide port io_wb_done  input  1  datapath finished current instruction.
REQ-014 SHALL provide port io_pc_next  input  32  next PC from the next-PC unit.
REQ-015 SHALL provide port io_is_unknown_instruction  input  1  decoder flags illegal instruction.
REQ-016 SHALL provide port io_halted  output  1  core stopped.
REQ-017 SHALL provide port io_halt_cause  output  2  0 none, 1 illegal instruction, 2 fetch timeout, 3 misaligned next PC.
REQ-018 SHALL provide port io_retired  output  32  count of retired instructions.

Function
REQ-019 SHALL implement FSM states FETCH, WAIT, EXEC, HALT; reset state FETCH.
REQ-020 FETCH: io_imem_req_valid=1; on req_ready=1 -> WAIT with timeout counter cleared; otherwise stay in FETCH with no timeout.
REQ-021 WAIT: req_valid=0; on resp_valid=1 -> latch resp_data into io_inst and go to EXEC; otherwise increment counter, and when counter reaches TIMEOUT-1 without a response -> HALT with cause 2.
REQ-022 resp_valid SHALL be ignored outside WAIT; a response in the same cycle as the request handshake SHALL NOT be captured.
REQ-023 EXEC: io_inst_valid=1; priority is unknown_instruction > wb_done.
REQ-024 EXEC with is_unknown_instruction=1 -> HALT with cause 1; PC and io_retired unchanged.
REQ-025 EXEC with wb_done=1 and io_pc_next[1:0]!=0 -> HALT with cause 3; PC and io_retired unchanged.
REQ-026 EXEC with wb_done=1 and aligned pc_next -> PC<=io_pc_next, io_retired+=1 (wraps at 2^32), go to FETCH.
REQ-027 EXEC without wb_done or unknown_instruction SHALL hold state; io_inst stays stable.
REQ-028 HALT SHALL be absorbing until reset: req_valid=0, inst_valid=0, io_halted=1, PC, io_inst and io_retired frozen.
REQ-029 The first fetch after reset SHALL be requested in the first cycle after reset deasserts, at RESET_PC.
REQ-030 io_imem_req_addr SHALL remain stable while req_valid=1 and ready=0.

Reset
REQ-031 Reset SHALL, asynchronously and in any state, force state FETCH, PC=RESET_PC, io_inst=0, io_retired=0, io_halt_cause=0, timeout counter=0.
REQ-032 During reset: io_imem_req_valid=0, io_inst_valid=0, io_halted=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the fetch; a late resp_valid arriving in the post-reset FETCH state SHALL be ignored.

Verification
REQ-034 Reset release, ready=1, response 2 cycles later with 32'h00000013, wb_done with pc_next=32'h80000004 -> io_inst=32'h00000013, PC=32'h80000004, io_retired=1, next request at 32'h80000004.
REQ-035 ready held low 10 cycles in FETCH -> no timeout, addr stable at 32'h80000000, handshake on cycle 11 -> WAIT.
REQ-036 No response after accepted request, TIMEOUT=4 -> HALT with cause 2 after 4 WAIT cycles; req_valid stays 0 afterwards.
REQ-037 EXEC with unknown_instruction=1 and wb_done=1 in the same cycle -> HALT with cause 1, PC unchanged, io_retired unchanged.
REQ-038 wb_done with pc_next=32'h80000102 -> HALT with cause 3, PC stays at the old value.
REQ-039 Reset pulsed in WAIT, then resp_valid=1 one cycle after release -> response ignored, fresh request at 32'h80000000, io_retired=0.
